// File: rtl/aes_pkg.sv
// Shared AES types, the FSM encoding and GF(2^8) helpers for the MixColumns engine.
// Optional build macro INV_MIXCOL_EN (used by the datapath files) adds InvMixColumns.
package aes_pkg;

  typedef logic [127:0] aes_state_t;
  typedef logic [31:0]  aes_col_t;
  typedef logic [7:0]   aes_byte_t;

  localparam aes_byte_t GF_POLY = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } aes_fsm_e;

  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Shift-and-add multiply; with a constant k it folds down to a few XOR/xtime terms.
  function automatic aes_byte_t gf_mul(input aes_byte_t a, input aes_byte_t k);
    aes_byte_t p;
    aes_byte_t x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_mixcol_column.sv
// Mixes one 32-bit column (row 0 in the top byte). With INV_MIXCOL_EN an inverse path
// with coefficients {0E,0B,0D,09} is added and selected by inv.
module aes_mixcol_column
  import aes_pkg::*;
(
`ifdef INV_MIXCOL_EN
  input  logic     inv,
`endif
  input  aes_col_t col,
  output aes_col_t mixed
);

  aes_byte_t fwd_b [4];
  aes_col_t  fwd;

  for (genvar r = 0; r < 4; r++) begin : g_row
    gf256_mixcol_byte #(.ROW_IDX(r)) u_byte (
      .col   (col),
      .mixed (fwd_b[r])
    );
  end

  assign fwd = {fwd_b[0], fwd_b[1], fwd_b[2], fwd_b[3]};

`ifdef INV_MIXCOL_EN
  aes_col_t inv_mix;

  for (genvar r = 0; r < 4; r++) begin : g_inv_row
    assign inv_mix[31-8*r -: 8] = gf_mul(col[31-8*r -: 8],             8'h0E)
                                ^ gf_mul(col[31-8*((r+1)%4) -: 8],     8'h0B)
                                ^ gf_mul(col[31-8*((r+2)%4) -: 8],     8'h0D)
                                ^ gf_mul(col[31-8*((r+3)%4) -: 8],     8'h09);
  end

  assign mixed = inv ? inv_mix : fwd;
`else
  assign mixed = fwd;
`endif

endmodule

// File: rtl/gf256_mixcol_byte.sv
// One output row of forward MixColumns: coefficients {02,03,01,01} rotated right by ROW_IDX.
module gf256_mixcol_byte
  import aes_pkg::*;
#(
  parameter int ROW_IDX = 0
) (
  input  aes_col_t  col,
  output aes_byte_t mixed
);

  localparam int R0 = ROW_IDX % 4;
  localparam int R1 = (ROW_IDX + 1) % 4;
  localparam int R2 = (ROW_IDX + 2) % 4;
  localparam int R3 = (ROW_IDX + 3) % 4;

  aes_byte_t a0, a1, a2, a3;

  assign a0 = col[31-8*R0 -: 8];
  assign a1 = col[31-8*R1 -: 8];
  assign a2 = col[31-8*R2 -: 8];
  assign a3 = col[31-8*R3 -: 8];

  // 2*a0 ^ 3*a1 ^ a2 ^ a3
  assign mixed = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;

endmodule

// File: rtl/aes_mixcol_seq.sv
// Column-serial MixColumns engine: COLS_PER_CYCLE columns are mixed in place per cycle.
// Build macro INV_MIXCOL_EN enables the in_inv (InvMixColumns) request.
module aes_mixcol_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  aes_state_t       in_state,
  input  logic             in_last,
  input  logic             in_inv,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output aes_state_t       out_state,
  output logic [TAG_W-1:0] out_tag
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("aes_mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [2:0] COL_STEP = 3'(COLS_PER_CYCLE);

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid holds its
  // data stable until then, and ready may be asserted independently of valid.
  aes_fsm_e           state_q;
  aes_col_t [3:0]     work_q;   // work_q[3] is column 0 (top of the state word)
  logic [1:0]         col_cnt_q;
  logic [TAG_W-1:0]   tag_q;
  logic [2:0]         cnt_sum;
  logic [1:0]         col_idx [COLS_PER_CYCLE];
  aes_col_t           col_in  [COLS_PER_CYCLE];
  aes_col_t           col_out [COLS_PER_CYCLE];

`ifdef INV_MIXCOL_EN
  logic inv_q;
`else
  wire unused_inv = in_inv;
`endif

  for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_col
    assign col_idx[j] = col_cnt_q + 2'(j);
    assign col_in[j]  = work_q[~col_idx[j]];

    aes_mixcol_column u_column (
`ifdef INV_MIXCOL_EN
      .inv   (inv_q),
`endif
      .col   (col_in[j]),
      .mixed (col_out[j])
    );
  end

  assign cnt_sum   = {1'b0, col_cnt_q} + COL_STEP;
  assign out_state = work_q;
  assign out_tag   = tag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      work_q    <= '0;
      col_cnt_q <= 2'd0;
      tag_q     <= '0;
`ifdef INV_MIXCOL_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            work_q    <= in_state;
            tag_q     <= in_tag;
            col_cnt_q <= 2'd0;
`ifdef INV_MIXCOL_EN
            inv_q     <= in_inv;
`endif
            if (in_last) begin
              state_q   <= DONE;
              out_valid <= 1'b1;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            work_q[~col_idx[j]] <= col_out[j];
          end
          col_cnt_q <= cnt_sum[1:0];
          if (cnt_sum == 3'd4) begin
            state_q   <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // in_ready stays low here so no accept can coincide with the output handshake.
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mixcol_seq.sv
// Directed bench: three engines (1, 2 and 4 columns per cycle) share one input stream.
module tb_aes_mixcol_seq;

  localparam int TAG_W = 4;

  localparam logic [127:0] V1_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] V1_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] V2_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  // Forward MixColumns applied to V1_OUT
  localparam logic [127:0] V3_FWD = 128'hc6b54f3a_1edcacc6_2ab78307_3002b6c0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid  = 1'b0;
  logic [127:0]     in_state  = '0;
  logic             in_last   = 1'b0;
  logic             in_inv    = 1'b0;
  logic [TAG_W-1:0] in_tag    = '0;
  logic             out_ready = 1'b0;

  logic             in_ready_a  [3];
  logic             out_valid_a [3];
  logic [127:0]     out_state_a [3];
  logic [TAG_W-1:0] out_tag_a   [3];

  int checks = 0;
  int errors = 0;
  int lat_a [3];
  int lat_exp [3] = '{5, 3, 2};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_mixcol_seq #(.COLS_PER_CYCLE(1 << g), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a[g]),
      .in_state  (in_state),
      .in_last   (in_last),
      .in_inv    (in_inv),
      .in_tag    (in_tag),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready),
      .out_state (out_state_a[g]),
      .out_tag   (out_tag_a[g])
    );
  end

  // ---------------- driver tasks ----------------
  task automatic wait_all_ready();
    int n = 0;
    while (!(in_ready_a[0] && in_ready_a[1] && in_ready_a[2]) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!(in_ready_a[0] && in_ready_a[1] && in_ready_a[2])) begin
      errors++;
      $display("FAIL wait_ready: in_ready=%b%b%b required 111", in_ready_a[0], in_ready_a[1], in_ready_a[2]);
    end
  endtask

  task automatic start_txn(input logic [127:0] s, input logic last, input logic inv,
                           input logic [TAG_W-1:0] tag);
    wait_all_ready();
    in_state = s;
    in_last  = last;
    in_inv   = inv;
    in_tag   = tag;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called right after the accept edge; lat_a[d] is the cycle index where out_valid is seen.
  task automatic wait_out();
    int n = 1;
    lat_a = '{0, 0, 0};
    for (int k = 0; k < 12; k++) begin
      for (int d = 0; d < 3; d++)
        if (out_valid_a[d] && lat_a[d] == 0) lat_a[d] = n;
      if (lat_a[0] != 0 && lat_a[1] != 0 && lat_a[2] != 0) break;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (in_ready_a[d] !== 1'b0 || out_valid_a[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_hs[%0d]: in_ready=%b out_valid=%b required 0 0", d, in_ready_a[d], out_valid_a[d]);
      end
      checks++;
      if (out_state_a[d] !== 128'h0 || out_tag_a[d] !== '0) begin
        errors++;
        $display("FAIL reset_data[%0d]: state=%h tag=%h required 0 0", d, out_state_a[d], out_tag_a[d]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (in_ready_a[d] !== 1'b1 || out_valid_a[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: in_ready=%b out_valid=%b required 1 0", d, in_ready_a[d], out_valid_a[d]);
      end
    end
  endtask

  task automatic test_mix(input string name, input logic [127:0] s, input logic inv,
                          input logic [127:0] exp, input logic [TAG_W-1:0] tag);
    start_txn(s, 1'b0, inv, tag);
    wait_out();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (lat_a[d] != lat_exp[d]) begin
        errors++;
        $display("FAIL %s_lat[%0d]: got %0d required %0d", name, d, lat_a[d], lat_exp[d]);
      end
      checks++;
      if (out_state_a[d] !== exp) begin
        errors++;
        $display("FAIL %s_state[%0d]: got %h required %h", name, d, out_state_a[d], exp);
      end
      checks++;
      if (out_tag_a[d] !== tag) begin
        errors++;
        $display("FAIL %s_tag[%0d]: got %h required %h", name, d, out_tag_a[d], tag);
      end
    end
    release_out();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (out_valid_a[d] !== 1'b0 || in_ready_a[d] !== 1'b1) begin
        errors++;
        $display("FAIL %s_release[%0d]: out_valid=%b in_ready=%b required 0 1", name, d, out_valid_a[d], in_ready_a[d]);
      end
    end
  endtask

  task automatic test_last();
    start_txn(V1_IN, 1'b1, 1'b1, 4'h3);
    wait_out();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (lat_a[d] != 1) begin
        errors++;
        $display("FAIL last_lat[%0d]: got %0d required 1", d, lat_a[d]);
      end
      checks++;
      if (out_state_a[d] !== V1_IN || in_ready_a[d] !== 1'b0) begin
        errors++;
        $display("FAIL last_state[%0d]: got %h ready=%b required %h ready=0", d, out_state_a[d], in_ready_a[d], V1_IN);
      end
    end
    release_out();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (in_ready_a[d] !== 1'b1) begin
        errors++;
        $display("FAIL last_ready[%0d]: got %b required 1", d, in_ready_a[d]);
      end
    end
  endtask

  task automatic test_backpressure();
    start_txn(V2_IN, 1'b0, 1'b0, 4'h9);
    wait_out();
    for (int c = 0; c < 7; c++) begin
      in_valid = 1'b1;
      in_state = ~V2_IN;
      in_last  = c[0];
      in_tag   = 4'(c);
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (out_valid_a[d] !== 1'b1 || in_ready_a[d] !== 1'b0 ||
            out_state_a[d] !== V2_OUT || out_tag_a[d] !== 4'h9) begin
          errors++;
          $display("FAIL bp_hold[%0d] c%0d: valid=%b ready=%b state=%h tag=%h required 1 0 %h 9",
                   d, c, out_valid_a[d], in_ready_a[d], out_state_a[d], out_tag_a[d], V2_OUT);
        end
      end
    end
    release_out();
    // Stray out_ready while idle must be ignored, and no ignored pulse may surface as a result.
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (out_valid_a[d] !== 1'b0 || in_ready_a[d] !== 1'b1) begin
        errors++;
        $display("FAIL bp_release[%0d]: out_valid=%b in_ready=%b required 0 1", d, out_valid_a[d], in_ready_a[d]);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    start_txn(V1_IN, 1'b0, 1'b0, 4'h2);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (out_valid_a[d] !== 1'b0) begin
        errors++;
        $display("FAIL rst_busy_valid[%0d]: got %b required 0", d, out_valid_a[d]);
      end
    end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (out_valid_a[d] !== 1'b0 || in_ready_a[d] !== 1'b1) begin
        errors++;
        $display("FAIL rst_busy_idle[%0d]: out_valid=%b in_ready=%b required 0 1", d, out_valid_a[d], in_ready_a[d]);
      end
    end
    test_mix("after_rst", V2_IN, 1'b0, V2_OUT, 4'h6);
  endtask

  task automatic test_inverse();
`ifdef INV_MIXCOL_EN
    test_mix("inverse", V1_OUT, 1'b1, V1_IN, 4'h7);
`else
    test_mix("inv_ignored", V1_OUT, 1'b1, V3_FWD, 4'h7);
`endif
  endtask

  initial begin
    test_reset();
    test_mix("fips", V1_IN, 1'b0, V1_OUT, 4'hA);
    test_mix("identity", V2_IN, 1'b0, V2_OUT, 4'h5);
    test_last();
    test_backpressure();
    test_reset_mid_busy();
    test_inverse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
